even_parity_checker: RTL and testbench
======================================

# even_parity_checker

Even-parity checker for a WIDTH-bit data word and its parity bit. It produces a combinational error flag `E` that is 1 when the data plus parity contain an odd number of ones. A clocked monitor alongside it registers the error, holds a sticky error flag, and counts checked words and failed words. It sits at the receive side of a parity-protected link, after the matching even-parity generator.

## Interface
Parameters:
- `WIDTH`, default 2: data word width, ≥1.
- `CNT_W`, default 16: width of the check and error counters, ≥2.

Ports (clock and reset listed first). Declaration order is `A`, `P`, `E`, `clk`, `rst_n`, `valid`, `clr`, `err_q`, `err_sticky`, `chk_cnt`, `err_cnt`; the first three must support positional binding.
- `clk`  in  1  single clock; all registers update on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `A`  in  WIDTH  received data word.
- `P`  in  1  received even-parity bit.
- `E`  out  1  combinational parity error, `^A ^ P`.
- `valid`  in  1  the current `A`/`P` is a word to be counted by the monitor.
- `clr`  in  1  synchronous clear of the monitor state.
- `err_q`  out  1  registered `E` for the last valid word.
- `err_sticky`  out  1  set when any valid word fails; held until cleared.
- `chk_cnt`  out  CNT_W  number of valid words checked; saturating.
- `err_cnt`  out  CNT_W  number of valid words that failed; saturating.

## Operation
- `E` is the XOR of all bits of `A` and `P`.
  - 0 means the total number of ones is even (no error).
  - 1 means the total is odd (error).
- `E` is purely combinational. It does not depend on `clk`, `rst_n`, `valid` or `clr`, and it must be correct even when those inputs are unconnected.
- Monitor behaviour on each rising `clk` edge, in priority order:
  - `clr` = 1: `err_q`, `err_sticky`, `chk_cnt` and `err_cnt` all go to 0. This applies even if `valid` = 1 in the same cycle; that word is discarded.
  - Otherwise, `valid` = 1:
    - `err_q` takes the value of `E`.
    - `chk_cnt` increments by 1, saturating at 2^CNT_W−1.
    - If `E` = 1, `err_cnt` increments by 1 (saturating) and `err_sticky` is set to 1.
  - Otherwise (`valid` = 0): all monitor registers hold their values.
- Saturation: a counter at its maximum value stays there and never wraps to 0.
- Invariant: `err_cnt` ≤ `chk_cnt` at all times.

## Timing
- `E` has zero cycles of latency: combinational from `A`/`P`, with no registers in the path.
- `err_q`, `err_sticky`, `chk_cnt` and `err_cnt` reflect a valid word one cycle after the `clk` edge that samples it.
- Reset: `rst_n` low immediately forces `err_q`, `err_sticky`, `chk_cnt` and `err_cnt` to 0, without waiting for a clock edge. They stay at 0 while `rst_n` is low. `E` keeps tracking its inputs during reset.
- Reset release: the first rising edge with `rst_n` high resumes normal operation.
- Reset asserted in the middle of a run discards all accumulated counts.
- `clr` and `valid` are sampled only on rising edges. There is no handshake and no backpressure; one word can be accepted every cycle.

## Test plan
- Exhaustive combinational sweep (WIDTH=2), stepping `A`/`P` through 00/0, 00/1, 01/0, 01/1, 10/0, 10/1, 11/0, 11/1 every 10 ns with no clock running. Required `E`: 0, 1, 1, 0, 1, 0, 0, 1.
- Reset values: assert `rst_n` = 0 mid-simulation with no clock edge. `err_q`, `err_sticky`, `chk_cnt` and `err_cnt` must all read 0 immediately, while `E` still follows `A`/`P`.
- Counting: after reset, apply 8 consecutive valid words in the sweep order above. Required result: `chk_cnt` = 8, `err_cnt` = 4, `err_sticky` = 1, and `err_q` = 1 (the last word, 11/1, fails).
- Hold and clear:
  - With `valid` = 0 and `A`/`P` = 01/0, all monitor outputs must hold for 5 cycles.
  - Then pulse `clr` together with `valid` = 1. All monitor outputs must read 0 on the next cycle.
- Saturation (CNT_W=2): apply 5 failing valid words. `chk_cnt` and `err_cnt` must both stop at 3.
- Parameter check (WIDTH=8): `A` = 8'hA5 with `P` = 0 gives `E` = 0; `A` = 8'hA4 with `P` = 0 gives `E` = 1.

Source files
------------

// File: rtl/even_parity_checker.sv
// Even-parity checker with a clocked monitor.
// E flags an odd number of ones across the data word and its parity bit.
// The monitor registers the last valid result, keeps a sticky error flag
// and counts checked and failed words with saturating counters.
module even_parity_checker #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic             P,
    output logic             E,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic             clr,
    output logic             err_q,
    output logic             err_sticky,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_ONE;
    endfunction

    // Parity error is purely combinational so it stays valid with clk/reset idle.
    assign E = (^A) ^ P;

    // Monitor registers: clear has priority over a valid word in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            err_sticky <= 1'b0;
            chk_cnt    <= '0;
            err_cnt    <= '0;
        end else if (clr) begin
            err_q      <= 1'b0;
            err_sticky <= 1'b0;
            chk_cnt    <= '0;
            err_cnt    <= '0;
        end else if (valid) begin
            err_q   <= E;
            chk_cnt <= sat_inc(chk_cnt);
            if (E) begin
                err_cnt    <= sat_inc(err_cnt);
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_even_parity_checker.sv
// Directed testbench for even_parity_checker: combinational sweep, async
// reset, counting, hold, clear, saturation and a wider data word.
module tb_even_parity_checker;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;

    // Main instance, WIDTH=2, CNT_W=16
    logic [1:0]  a2 = 2'b00;
    logic        p2 = 1'b0;
    logic        valid = 1'b0;
    logic        e2;
    logic        err_q;
    logic        err_sticky;
    logic [15:0] chk_cnt;
    logic [15:0] err_cnt;

    // Saturation instance, WIDTH=2, CNT_W=2
    logic [1:0] a_s = 2'b00;
    logic       p_s = 1'b0;
    logic       valid_s = 1'b0;
    logic       e_s;
    logic       err_q_s;
    logic       err_sticky_s;
    logic [1:0] chk_cnt_s;
    logic [1:0] err_cnt_s;

    // Wide instance, WIDTH=8
    logic [7:0]  a8 = 8'h00;
    logic        p8 = 1'b0;
    logic        valid8 = 1'b0;
    logic        e8;
    logic        err_q8;
    logic        err_sticky8;
    logic [15:0] chk_cnt8;
    logic [15:0] err_cnt8;

    int checks = 0;
    int errors = 0;

    // Sweep table with hand-computed parity errors
    logic [1:0] sw_a [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic       sw_p [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       sw_e [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    even_parity_checker #(.WIDTH(2), .CNT_W(16)) dut (
        .A(a2), .P(p2), .E(e2), .clk(clk), .rst_n(rst_n), .valid(valid), .clr(clr),
        .err_q(err_q), .err_sticky(err_sticky), .chk_cnt(chk_cnt), .err_cnt(err_cnt)
    );

    even_parity_checker #(.WIDTH(2), .CNT_W(2)) dut_sat (
        .A(a_s), .P(p_s), .E(e_s), .clk(clk), .rst_n(rst_n), .valid(valid_s), .clr(clr),
        .err_q(err_q_s), .err_sticky(err_sticky_s), .chk_cnt(chk_cnt_s), .err_cnt(err_cnt_s)
    );

    even_parity_checker #(.WIDTH(8), .CNT_W(16)) dut_w8 (
        .A(a8), .P(p8), .E(e8), .clk(clk), .rst_n(rst_n), .valid(valid8), .clr(clr),
        .err_q(err_q8), .err_sticky(err_sticky8), .chk_cnt(chk_cnt8), .err_cnt(err_cnt8)
    );

    // Gated clock so the combinational sweep can run with no edges
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_monitor(input string tag, input logic q, input logic s,
                                 input int c, input int ec);
        check({tag, "_err_q"}, 32'(err_q), 32'(q));
        check({tag, "_sticky"}, 32'(err_sticky), 32'(s));
        check({tag, "_chk_cnt"}, 32'(chk_cnt), 32'(c));
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(ec));
    endtask

    initial begin
        // Initial reset with clock stopped
        #10;
        check_monitor("init_rst", 1'b0, 1'b0, 0, 0);
        rst_n = 1'b1;
        #5;

        // Exhaustive combinational sweep, no clock running
        for (int i = 0; i < 8; i++) begin
            a2 = sw_a[i];
            p2 = sw_p[i];
            #10;
            check($sformatf("sweep_E_%0d", i), 32'(e2), 32'(sw_e[i]));
        end

        // Wide word parity
        a8 = 8'hA5; p8 = 1'b0; #1;
        check("w8_A5_p0", 32'(e8), 32'd0);
        a8 = 8'hA4; p8 = 1'b0; #1;
        check("w8_A4_p0", 32'(e8), 32'd1);
        a8 = 8'hA4; p8 = 1'b1; #1;
        check("w8_A4_p1", 32'(e8), 32'd0);

        // Start clock and accumulate some state before a mid-run reset
        clk_en = 1'b1;
        step();
        a2 = 2'b01; p2 = 1'b0; valid = 1'b1;
        step();
        step();
        valid = 1'b0;
        check_monitor("dirty", 1'b1, 1'b1, 2, 2);

        // Async reset: monitor clears without a clock edge, E keeps tracking
        #2;
        rst_n = 1'b0;
        #1;
        check_monitor("async_rst", 1'b0, 1'b0, 0, 0);
        a2 = 2'b11; p2 = 1'b0; #0.5;
        check("rst_E_11_0", 32'(e2), 32'd0);
        a2 = 2'b10; p2 = 1'b0; #0.5;
        check("rst_E_10_0", 32'(e2), 32'd1);
        step();
        check_monitor("rst_held", 1'b0, 1'b0, 0, 0);
        rst_n = 1'b1;
        step();

        // Count 8 valid words in sweep order
        for (int i = 0; i < 8; i++) begin
            a2 = sw_a[i];
            p2 = sw_p[i];
            valid = 1'b1;
            step();
            check($sformatf("cnt_err_q_%0d", i), 32'(err_q), 32'(sw_e[i]));
            check($sformatf("cnt_chk_%0d", i), 32'(chk_cnt), 32'(i + 1));
        end
        valid = 1'b0;
        check_monitor("count8", 1'b1, 1'b1, 8, 4);

        // Hold for 5 cycles with a failing word present but not valid
        a2 = 2'b01; p2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_monitor($sformatf("hold_%0d", i), 1'b1, 1'b1, 8, 4);
        end

        // Clear wins over a valid failing word in the same cycle
        clr = 1'b1; valid = 1'b1;
        step();
        clr = 1'b0; valid = 1'b0;
        check_monitor("clr", 1'b0, 1'b0, 0, 0);

        // Saturation on the narrow-counter instance
        a_s = 2'b01; p_s = 1'b0; valid_s = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("sat_chk_%0d", i), 32'(chk_cnt_s), (i < 3) ? 32'(i + 1) : 32'd3);
            check($sformatf("sat_err_%0d", i), 32'(err_cnt_s), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        valid_s = 1'b0;
        check("sat_sticky", 32'(err_sticky_s), 32'd1);
        check("sat_err_q", 32'(err_q_s), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
